// File: rtl/wk_scheduler.sv
// -----------------------------------------------------------------------------
// wk_scheduler
//
// Message-schedule stage that sits directly in front of the hash round
// datapath. A 512-bit chunk arrives as 16 big-endian 32-bit words over a
// valid/ready handshake. The chunk is then expanded on the fly in a 16-word
// sliding window. One pre-added wk = W[t] + K[t] is presented per round,
// together with its round index. The downstream controller paces the rounds
// with its advance strobe.
//
// Ports:
//   clk         in   rising-edge clock
//   reset_n     in   asynchronous active-low reset
//   start       in   one-cycle pulse: latch opcode, begin loading a chunk
//   opcode      in   [1:0] hash select: 0 = MD5, 1 = SHA_1, 2 = SHA_256, 3 = reserved
//   word_in     in   [31:0] message word, word 0 of the chunk first
//   word_valid  in   word_in is valid
//   word_ready  out  a word is accepted this cycle (registered, high in LOAD)
//   advance     in   downstream consumed the current wk; step to next round
//   wk          out  [31:0] W[round] + K[round] mod 2^32
//   round       out  [ROUND_W-1:0] round index of the current wk
//   wk_valid    out  wk/round are valid
//   block_done  out  one-cycle pulse after the last round is consumed
//   err         out  one-cycle pulse: start issued with an unsupported opcode
//
// Parameters:
//   ROUND_W     width of the round output (must hold 79)
//
// Configuration:
//   WK_SCHED_SHA1_EN  when defined, SHA_1 is accepted and the SHA-1 expansion
//                     and K logic is built. When undefined, only SHA_256 is
//                     accepted. SHA_1 then raises err like MD5 does.
// -----------------------------------------------------------------------------
module wk_scheduler #(
  parameter int ROUND_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [1:0]         opcode,
  input  logic [31:0]        word_in,
  input  logic               word_valid,
  output logic               word_ready,
  input  logic               advance,
  output logic [31:0]        wk,
  output logic [ROUND_W-1:0] round,
  output logic               wk_valid,
  output logic               block_done,
  output logic               err
);

  localparam logic [1:0] OP_SHA_256 = 2'd2;
`ifdef WK_SCHED_SHA1_EN
  localparam logic [1:0] OP_SHA_1   = 2'd1;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t             r_state;
  logic [3:0]         r_loadCnt;
  logic [31:0]        r_win [16];
  logic [31:0]        r_wk;
  logic [ROUND_W-1:0] r_round;
  logic               r_wkValid;
  logic               r_wordReady;
  logic               r_blockDone;
  logic               r_err;
`ifdef WK_SCHED_SHA1_EN
  logic               r_isSha1;
`endif

  logic               w_isSha1;
  logic               w_opOk;
  logic               w_accept;
  logic               w_advance;
  logic [ROUND_W-1:0] w_roundNext;
  logic [ROUND_W-1:0] w_lastRound;
  logic [6:0]         w_kIdx;
  logic [31:0]        w_k;
  logic [31:0]        w_s0;
  logic [31:0]        w_s1;
  logic [31:0]        w_nextWord;
  logic [31:0]        w_wkNext;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

`ifdef WK_SCHED_SHA1_EN
  function automatic logic [31:0] rotl1(input logic [31:0] x);
    return {x[30:0], x[31]};
  endfunction
`endif

  // SHA-256 round constants: the standard table, indexed by round.
  function automatic logic [31:0] sha256K(input logic [5:0] idx);
    logic [31:0] k;
    case (idx)
      6'd0:  k = 32'h428a2f98;
      6'd1:  k = 32'h71374491;
      6'd2:  k = 32'hb5c0fbcf;
      6'd3:  k = 32'he9b5dba5;
      6'd4:  k = 32'h3956c25b;
      6'd5:  k = 32'h59f111f1;
      6'd6:  k = 32'h923f82a4;
      6'd7:  k = 32'hab1c5ed5;
      6'd8:  k = 32'hd807aa98;
      6'd9:  k = 32'h12835b01;
      6'd10: k = 32'h243185be;
      6'd11: k = 32'h550c7dc3;
      6'd12: k = 32'h72be5d74;
      6'd13: k = 32'h80deb1fe;
      6'd14: k = 32'h9bdc06a7;
      6'd15: k = 32'hc19bf174;
      6'd16: k = 32'he49b69c1;
      6'd17: k = 32'hefbe4786;
      6'd18: k = 32'h0fc19dc6;
      6'd19: k = 32'h240ca1cc;
      6'd20: k = 32'h2de92c6f;
      6'd21: k = 32'h4a7484aa;
      6'd22: k = 32'h5cb0a9dc;
      6'd23: k = 32'h76f988da;
      6'd24: k = 32'h983e5152;
      6'd25: k = 32'ha831c66d;
      6'd26: k = 32'hb00327c8;
      6'd27: k = 32'hbf597fc7;
      6'd28: k = 32'hc6e00bf3;
      6'd29: k = 32'hd5a79147;
      6'd30: k = 32'h06ca6351;
      6'd31: k = 32'h14292967;
      6'd32: k = 32'h27b70a85;
      6'd33: k = 32'h2e1b2138;
      6'd34: k = 32'h4d2c6dfc;
      6'd35: k = 32'h53380d13;
      6'd36: k = 32'h650a7354;
      6'd37: k = 32'h766a0abb;
      6'd38: k = 32'h81c2c92e;
      6'd39: k = 32'h92722c85;
      6'd40: k = 32'ha2bfe8a1;
      6'd41: k = 32'ha81a664b;
      6'd42: k = 32'hc24b8b70;
      6'd43: k = 32'hc76c51a3;
      6'd44: k = 32'hd192e819;
      6'd45: k = 32'hd6990624;
      6'd46: k = 32'hf40e3585;
      6'd47: k = 32'h106aa070;
      6'd48: k = 32'h19a4c116;
      6'd49: k = 32'h1e376c08;
      6'd50: k = 32'h2748774c;
      6'd51: k = 32'h34b0bcb5;
      6'd52: k = 32'h391c0cb3;
      6'd53: k = 32'h4ed8aa4a;
      6'd54: k = 32'h5b9cca4f;
      6'd55: k = 32'h682e6ff3;
      6'd56: k = 32'h748f82ee;
      6'd57: k = 32'h78a5636f;
      6'd58: k = 32'h84c87814;
      6'd59: k = 32'h8cc70208;
      6'd60: k = 32'h90befffa;
      6'd61: k = 32'ha4506ceb;
      6'd62: k = 32'hbef9a3f7;
      6'd63: k = 32'hc67178f2;
      default: k = 32'h0;
    endcase
    return k;
  endfunction

  // Decide which opcodes are accepted by start, and which hash the
  // running chunk belongs to.
  always_comb begin
    w_opOk   = (opcode == OP_SHA_256);
    w_isSha1 = 1'b0;
`ifdef WK_SCHED_SHA1_EN
    if (opcode == OP_SHA_1) w_opOk = 1'b1;
    w_isSha1 = r_isSha1;
`endif
  end

  // Handshake qualifiers and round bookkeeping. wk is precomputed for the
  // round that becomes current on the next edge. That round is round 0 when
  // the load completes, and round+1 on an advance.
  always_comb begin
    w_accept    = (r_state == LOAD) && r_wordReady && word_valid;
    w_advance   = (r_state == RUN) && r_wkValid && advance;
    w_roundNext = r_round + ROUND_W'(1);
    w_lastRound = w_isSha1 ? ROUND_W'(79) : ROUND_W'(63);
    w_kIdx      = (r_state == RUN) ? w_roundNext[6:0] : 7'd0;
  end

  // K for the upcoming round. SHA-1 uses one constant per 20-round quarter.
  always_comb begin
    w_k = w_kIdx[6] ? 32'h0 : sha256K(w_kIdx[5:0]);
`ifdef WK_SCHED_SHA1_EN
    if (w_isSha1) begin
      if (w_kIdx < 7'd20)      w_k = 32'h5a827999;
      else if (w_kIdx < 7'd40) w_k = 32'h6ed9eba1;
      else if (w_kIdx < 7'd60) w_k = 32'h8f1bbcdc;
      else                     w_k = 32'hca62c1d6;
    end
`endif
  end

  // Slot i of the window holds W[round+i]. The word appended on an advance
  // is W[round+16], so the taps for t-2, t-7, t-15 and t-16 are slots 14,
  // 9, 1 and 0. After the shift, slot 1 becomes the current word, so wk is
  // always formed from slot 1.
  always_comb begin
    w_s0       = rotr(r_win[1], 7) ^ rotr(r_win[1], 18) ^ (r_win[1] >> 3);
    w_s1       = rotr(r_win[14], 17) ^ rotr(r_win[14], 19) ^ (r_win[14] >> 10);
    w_nextWord = w_s1 + r_win[9] + w_s0 + r_win[0];
`ifdef WK_SCHED_SHA1_EN
    if (w_isSha1) w_nextWord = rotl1(r_win[13] ^ r_win[8] ^ r_win[2] ^ r_win[0]);
`endif
    w_wkNext   = r_win[1] + w_k;
  end

  // Control FSM, window and registered outputs. A start in any state
  // overrides whatever is in flight. A supported opcode restarts LOAD with
  // no block_done. An unsupported opcode drops back to IDLE with an err
  // pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_loadCnt   <= '0;
      r_wk        <= '0;
      r_round     <= '0;
      r_wkValid   <= 1'b0;
      r_wordReady <= 1'b0;
      r_blockDone <= 1'b0;
      r_err       <= 1'b0;
`ifdef WK_SCHED_SHA1_EN
      r_isSha1    <= 1'b0;
`endif
      for (int i = 0; i < 16; i++) r_win[i] <= '0;
    end else begin
      r_blockDone <= 1'b0;
      r_err       <= 1'b0;
      if (start) begin
        r_wkValid <= 1'b0;
        r_loadCnt <= '0;
        if (w_opOk) begin
          r_state     <= LOAD;
          r_wordReady <= 1'b1;
`ifdef WK_SCHED_SHA1_EN
          r_isSha1    <= (opcode == OP_SHA_1);
`endif
        end else begin
          r_state     <= IDLE;
          r_wordReady <= 1'b0;
          r_err       <= 1'b1;
        end
      end else begin
        case (r_state)
          LOAD: begin
            if (w_accept) begin
              for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
              r_win[15] <= word_in;
              r_loadCnt <= r_loadCnt + 4'd1;
              if (r_loadCnt == 4'd15) begin
                r_state     <= RUN;
                r_wordReady <= 1'b0;
                r_round     <= '0;
                r_wk        <= w_wkNext;
                r_wkValid   <= 1'b1;
              end
            end
          end
          RUN: begin
            if (w_advance) begin
              if (r_round == w_lastRound) begin
                r_state     <= IDLE;
                r_wkValid   <= 1'b0;
                r_blockDone <= 1'b1;
              end else begin
                for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
                r_win[15] <= w_nextWord;
                r_round   <= w_roundNext;
                r_wk      <= w_wkNext;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign word_ready = r_wordReady;
  assign wk         = r_wk;
  assign round      = r_round;
  assign wk_valid   = r_wkValid;
  assign block_done = r_blockDone;
  assign err        = r_err;

endmodule

// File: tb/tb_wk_scheduler.sv
// -----------------------------------------------------------------------------
// tb_wk_scheduler
//
// Directed bench for wk_scheduler. Inputs are driven and outputs sampled on
// the falling clock edge. The expected wk streams come from a plain
// array-based message expansion of the "abc" chunk. Key rounds are also
// checked against hand-computed constants.
// -----------------------------------------------------------------------------
module tb_wk_scheduler;

  localparam logic [1:0] OP_MD5 = 2'd0, OP_SHA_1 = 2'd1, OP_SHA_256 = 2'd2, OP_RSVD = 2'd3;

  logic        clk, reset_n, start, word_valid, advance;
  logic [1:0]  opcode;
  logic [31:0] word_in;
  logic        word_ready, wk_valid, block_done, err;
  logic [31:0] wk;
  logic [7:0]  round;

  int numChecks, numFails;
  int doneSeen = 0;

  logic [31:0] chunk  [16];
  logic [31:0] kTab   [64];
  logic [31:0] exp256 [64];
`ifdef WK_SCHED_SHA1_EN
  logic [31:0] exp1   [80];
`endif

  wk_scheduler #(.ROUND_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .opcode(opcode),
    .word_in(word_in), .word_valid(word_valid), .word_ready(word_ready),
    .advance(advance), .wk(wk), .round(round), .wk_valid(wk_valid),
    .block_done(block_done), .err(err)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tally every block_done pulse so scenarios can assert that none occurred.
  always @(negedge clk) if (block_done === 1'b1) doneSeen++;

  // Hard stop in case something hangs outside the bounded loops.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Build the reference wk streams for the "abc" chunk.
  task automatic buildModel();
    logic [31:0] w [80];
    chunk = '{32'h61626380, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
              32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00000018};
    kTab = '{32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
             32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
             32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
             32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
             32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
             32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
             32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
             32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    for (int t = 0; t < 16; t++) w[t] = chunk[t];
    for (int t = 16; t < 64; t++)
      w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    for (int t = 0; t < 64; t++) exp256[t] = w[t] + kTab[t];
`ifdef WK_SCHED_SHA1_EN
    for (int t = 16; t < 80; t++) w[t] = rr(w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16], 31);
    for (int t = 0; t < 16; t++) w[t] = chunk[t];
    for (int t = 16; t < 80; t++) w[t] = rr(w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16], 31);
    for (int t = 0; t < 80; t++)
      exp1[t] = w[t] + ((t < 20) ? 32'h5a827999 : (t < 40) ? 32'h6ed9eba1 : (t < 60) ? 32'h8f1bbcdc : 32'hca62c1d6);
`endif
  endtask

  // Pulse start for one cycle. Called and returns on a falling edge.
  task automatic applyStart(input logic [1:0] op);
    start = 1'b1; opcode = op;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present the 16 chunk words, optionally with an idle cycle after each.
  task automatic applyChunk(input bit gapped);
    for (int i = 0; i < 16; i++) begin
      word_valid = 1'b1; word_in = chunk[i];
      @(negedge clk);
      if (gapped && i < 15) begin
        word_valid = 1'b0; word_in = 32'hdeadbeef;
        @(negedge clk);
      end
    end
    word_valid = 1'b0; word_in = 32'h0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; opcode = OP_SHA_256; word_in = '0; word_valid = 1'b0; advance = 1'b0;
    #12;
    numChecks++; if (word_ready !== 1'b0) begin numFails++; $display("[TB] FAIL reset_word_ready: got %b want 0", word_ready); end
    numChecks++; if (wk_valid !== 1'b0) begin numFails++; $display("[TB] FAIL reset_wk_valid: got %b want 0", wk_valid); end
    numChecks++; if (wk !== 32'h0) begin numFails++; $display("[TB] FAIL reset_wk: got %h want 0", wk); end
    numChecks++; if (round !== 8'h0) begin numFails++; $display("[TB] FAIL reset_round: got %0d want 0", round); end
    numChecks++; if (block_done !== 1'b0 || err !== 1'b0) begin numFails++; $display("[TB] FAIL reset_pulses: got done=%b err=%b want 0/0", block_done, err); end
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    numChecks++; if (word_ready !== 1'b0) begin numFails++; $display("[TB] FAIL reset_idle_ready: got %b want 0", word_ready); end
  endtask

  task automatic test_md5();
    applyStart(OP_MD5);
    numChecks++; if (err !== 1'b1) begin numFails++; $display("[TB] FAIL md5_err: got %b want 1", err); end
    numChecks++; if (word_ready !== 1'b0) begin numFails++; $display("[TB] FAIL md5_ready: got %b want 0", word_ready); end
    @(negedge clk);
    numChecks++; if (err !== 1'b0) begin numFails++; $display("[TB] FAIL md5_err_one_cycle: got %b want 0", err); end
    numChecks++; if (word_ready !== 1'b0 || wk_valid !== 1'b0) begin numFails++; $display("[TB] FAIL md5_stay_idle: got ready=%b valid=%b want 0/0", word_ready, wk_valid); end
    applyStart(OP_RSVD);
    numChecks++; if (err !== 1'b1) begin numFails++; $display("[TB] FAIL rsvd_err: got %b want 1", err); end
    @(negedge clk);
  endtask

  task automatic test_sha256();
    int hs; bit fin; logic [31:0] w15, w16, w17;
    hs = 0; fin = 1'b0; w15 = '0; w16 = '0; w17 = '0;
    applyStart(OP_SHA_256);
    numChecks++; if (word_ready !== 1'b1 || err !== 1'b0) begin numFails++; $display("[TB] FAIL sha256_load_entry: got ready=%b err=%b want 1/0", word_ready, err); end
    applyChunk(1'b0);
    numChecks++; if (word_ready !== 1'b0) begin numFails++; $display("[TB] FAIL sha256_ready_drop: got %b want 0", word_ready); end
    numChecks++; if (wk_valid !== 1'b1 || round !== 8'd0) begin numFails++; $display("[TB] FAIL sha256_first_latency: got valid=%b round=%0d want 1/0", wk_valid, round); end
    numChecks++; if (wk !== 32'ha3ec9318) begin numFails++; $display("[TB] FAIL sha256_r0_wk: got %h want a3ec9318", wk); end
    advance = 1'b1;
    for (int cyc = 0; cyc < 100 && !fin; cyc++) begin
      if (wk_valid === 1'b1) begin
        if (hs >= 64) begin numChecks++; numFails++; $display("[TB] FAIL sha256_overrun: got round %0d want at most 63", round); fin = 1'b1; end
        else begin
          numChecks++; if (round !== 8'(hs)) begin numFails++; $display("[TB] FAIL sha256_round: got %0d want %0d", round, hs); end
          numChecks++; if (wk !== exp256[hs]) begin numFails++; $display("[TB] FAIL sha256_wk[%0d]: got %h want %h", hs, wk, exp256[hs]); end
          if (hs == 15) w15 = wk;
          if (hs == 16) w16 = wk;
          if (hs == 17) w17 = wk;
          hs++;
          @(negedge clk);
        end
      end else fin = 1'b1;
    end
    advance = 1'b0;
    numChecks++; if (fin !== 1'b1) begin numFails++; $display("[TB] FAIL sha256_timeout: got no end after %0d rounds", hs); end
    numChecks++; if (hs != 64) begin numFails++; $display("[TB] FAIL sha256_handshakes: got %0d want 64", hs); end
    numChecks++; if (block_done !== 1'b1) begin numFails++; $display("[TB] FAIL sha256_block_done: got %b want 1", block_done); end
    numChecks++; if (w15 !== 32'hc19bf18c) begin numFails++; $display("[TB] FAIL sha256_r15_wk: got %h want c19bf18c", w15); end
    numChecks++; if (w16 !== 32'h45fdcd41) begin numFails++; $display("[TB] FAIL sha256_r16_wk: got %h want 45fdcd41", w16); end
    numChecks++; if (w17 !== 32'hefcd4786) begin numFails++; $display("[TB] FAIL sha256_r17_wk: got %h want efcd4786", w17); end
    @(negedge clk);
    numChecks++; if (block_done !== 1'b0) begin numFails++; $display("[TB] FAIL sha256_done_one_cycle: got %b want 0", block_done); end
    numChecks++; if (wk_valid !== 1'b0 || round !== 8'd63 || wk !== exp256[63]) begin numFails++; $display("[TB] FAIL sha256_hold_last: got valid=%b round=%0d wk=%h want 0/63/%h", wk_valid, round, wk, exp256[63]); end
  endtask

  task automatic test_sha1();
`ifdef WK_SCHED_SHA1_EN
    int hs; bit fin;
    hs = 0; fin = 1'b0;
    applyStart(OP_SHA_1);
    numChecks++; if (word_ready !== 1'b1 || err !== 1'b0) begin numFails++; $display("[TB] FAIL sha1_load_entry: got ready=%b err=%b want 1/0", word_ready, err); end
    applyChunk(1'b0);
    numChecks++; if (wk !== 32'hbbe4dd19) begin numFails++; $display("[TB] FAIL sha1_r0_wk: got %h want bbe4dd19", wk); end
    advance = 1'b1;
    for (int cyc = 0; cyc < 120 && !fin; cyc++) begin
      if (wk_valid === 1'b1) begin
        if (hs >= 80) begin numChecks++; numFails++; $display("[TB] FAIL sha1_overrun: got round %0d want at most 79", round); fin = 1'b1; end
        else begin
          numChecks++; if (round !== 8'(hs) || wk !== exp1[hs]) begin numFails++; $display("[TB] FAIL sha1_wk[%0d]: got round=%0d wk=%h want %0d/%h", hs, round, wk, hs, exp1[hs]); end
          hs++;
          @(negedge clk);
        end
      end else fin = 1'b1;
    end
    advance = 1'b0;
    numChecks++; if (fin !== 1'b1 || hs != 80) begin numFails++; $display("[TB] FAIL sha1_handshakes: got %0d want 80", hs); end
    numChecks++; if (block_done !== 1'b1) begin numFails++; $display("[TB] FAIL sha1_block_done: got %b want 1", block_done); end
    @(negedge clk);
`else
    applyStart(OP_SHA_1);
    numChecks++; if (err !== 1'b1) begin numFails++; $display("[TB] FAIL sha1_disabled_err: got %b want 1", err); end
    numChecks++; if (word_ready !== 1'b0) begin numFails++; $display("[TB] FAIL sha1_disabled_ready: got %b want 0", word_ready); end
    @(negedge clk);
    numChecks++; if (err !== 1'b0 || word_ready !== 1'b0 || wk_valid !== 1'b0) begin numFails++; $display("[TB] FAIL sha1_disabled_idle: got err=%b ready=%b valid=%b want 0/0/0", err, word_ready, wk_valid); end
`endif
  endtask

  task automatic test_backpressure();
    int hs; bit fin;
    hs = 0; fin = 1'b0;
    applyStart(OP_SHA_256);
    applyChunk(1'b1);
    numChecks++; if (wk_valid !== 1'b1 || round !== 8'd0 || wk !== 32'ha3ec9318) begin numFails++; $display("[TB] FAIL bp_load_r0: got valid=%b round=%0d wk=%h want 1/0/a3ec9318", wk_valid, round, wk); end
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      advance = (cyc % 2 == 1);
      if (wk_valid === 1'b1) begin
        if (hs >= 64) begin numChecks++; numFails++; $display("[TB] FAIL bp_overrun: got round %0d want at most 63", round); fin = 1'b1; end
        else begin
          numChecks++; if (round !== 8'(hs) || wk !== exp256[hs]) begin numFails++; $display("[TB] FAIL bp_wk[%0d]: got round=%0d wk=%h want %0d/%h", hs, round, wk, hs, exp256[hs]); end
          if (advance) hs++;
          @(negedge clk);
        end
      end else fin = 1'b1;
    end
    advance = 1'b0;
    numChecks++; if (fin !== 1'b1 || hs != 64) begin numFails++; $display("[TB] FAIL bp_handshakes: got %0d want 64", hs); end
    numChecks++; if (block_done !== 1'b1) begin numFails++; $display("[TB] FAIL bp_block_done: got %b want 1", block_done); end
    @(negedge clk);
  endtask

  task automatic test_abort();
    int snap; bit reached;
    reached = 1'b0;
    applyStart(OP_SHA_256);
    applyChunk(1'b0);
    snap = doneSeen;
    advance = 1'b1;
    for (int cyc = 0; cyc < 60 && !reached; cyc++) begin
      if (wk_valid === 1'b1 && round === 8'd30) reached = 1'b1;
      else @(negedge clk);
    end
    numChecks++; if (reached !== 1'b1 || wk !== exp256[30]) begin numFails++; $display("[TB] FAIL abort_reach_r30: got reached=%b wk=%h want 1/%h", reached, wk, exp256[30]); end
    start = 1'b1; opcode = OP_SHA_256;
    @(negedge clk);
    start = 1'b0; advance = 1'b0;
    numChecks++; if (wk_valid !== 1'b0 || word_ready !== 1'b1) begin numFails++; $display("[TB] FAIL abort_restart: got valid=%b ready=%b want 0/1", wk_valid, word_ready); end
    applyChunk(1'b0);
    numChecks++; if (wk_valid !== 1'b1 || round !== 8'd0 || wk !== 32'ha3ec9318) begin numFails++; $display("[TB] FAIL abort_reload_r0: got valid=%b round=%0d wk=%h want 1/0/a3ec9318", wk_valid, round, wk); end
    numChecks++; if (doneSeen != snap) begin numFails++; $display("[TB] FAIL abort_no_done: got %0d pulses want 0", doneSeen - snap); end
  endtask

  task automatic test_reset_mid();
    applyStart(OP_SHA_256);
    for (int i = 0; i < 5; i++) begin word_valid = 1'b1; word_in = chunk[i]; @(negedge clk); end
    word_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    numChecks++; if (word_ready !== 1'b0 || wk_valid !== 1'b0) begin numFails++; $display("[TB] FAIL reset_mid_load: got ready=%b valid=%b want 0/0", word_ready, wk_valid); end
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    numChecks++; if (word_ready !== 1'b0) begin numFails++; $display("[TB] FAIL reset_mid_load_idle: got %b want 0", word_ready); end
    applyStart(OP_SHA_256);
    applyChunk(1'b0);
    advance = 1'b1;
    repeat (5) @(negedge clk);
    advance = 1'b0;
    numChecks++; if (round !== 8'd5 || wk !== exp256[5]) begin numFails++; $display("[TB] FAIL pre_reset_r5: got round=%0d wk=%h want 5/%h", round, wk, exp256[5]); end
    #2 reset_n = 1'b0;
    #1;
    numChecks++; if (wk_valid !== 1'b0 || wk !== 32'h0 || round !== 8'd0) begin numFails++; $display("[TB] FAIL reset_mid_run: got valid=%b wk=%h round=%0d want 0/0/0", wk_valid, wk, round); end
    numChecks++; if (word_ready !== 1'b0 || block_done !== 1'b0 || err !== 1'b0) begin numFails++; $display("[TB] FAIL reset_mid_run_flags: got ready=%b done=%b err=%b want 0/0/0", word_ready, block_done, err); end
    @(negedge clk); reset_n = 1'b1;
    word_valid = 1'b1; word_in = 32'h12345678;
    repeat (2) @(negedge clk);
    word_valid = 1'b0;
    numChecks++; if (word_ready !== 1'b0 || wk_valid !== 1'b0) begin numFails++; $display("[TB] FAIL idle_ignores_words: got ready=%b valid=%b want 0/0", word_ready, wk_valid); end
    applyStart(OP_SHA_256);
    applyChunk(1'b0);
    numChecks++; if (wk_valid !== 1'b1 || wk !== 32'ha3ec9318) begin numFails++; $display("[TB] FAIL post_reset_r0: got valid=%b wk=%h want 1/a3ec9318", wk_valid, wk); end
  endtask

  initial begin
    numChecks = 0; numFails = 0;
    buildModel();
    test_reset();
    test_md5();
    test_sha256();
    test_sha1();
    test_backpressure();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
